// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage 8-bit pipeline control slice.
package pipe_pkg;

  localparam int unsigned REG_W  = 3;
  localparam int unsigned PC_W   = 12;
  localparam int unsigned DATA_W = 8;

  localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

  typedef enum logic [2:0] {
    StInit,
    StRun,
    StLdStall,
    StMemWait,
    StDrain,
    StHalted
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_IN,
  input  logic             clr_IN,
  output logic [CNT_W-1:0] cnt_OUT
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_IN) begin
      r_cnt <= '0;
    end else if (inc_IN && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_OUT = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: owns every pipeline-register enable/flush; handles load-use bubbles,
// EXE-resolved branch flushes, data-memory freezes and HALT drain.
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int unsigned LDUSE_CYC = 1,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] idRs_IN,
  input  logic [REG_W-1:0] idRt_IN,
  input  logic             idUsesRs_IN,
  input  logic             idUsesRt_IN,
  input  logic [REG_W-1:0] exRd_IN,
  input  logic             exMemRd_IN,
  input  logic             exBrTaken_IN,
  input  logic             memReq_IN,
  input  logic             memAck_IN,
  input  logic             haltReq_IN,
  input  logic             resume_IN,
  output logic             pcWr_OUT,
  output logic             pcSelBr_OUT,
  output logic             ifidWr_OUT,
  output logic             ifidFlush_OUT,
  output logic             idexWr_OUT,
  output logic             idexFlush_OUT,
  output logic             exmemWr_OUT,
  output logic             memwbFlush_OUT,
  output logic             halted_OUT,
  output logic [CNT_W-1:0] stallCnt_OUT,
  output logic [CNT_W-1:0] flushCnt_OUT
);

  localparam logic [7:0] LdLoad = 8'(LDUSE_CYC - 1);
  localparam logic [7:0] DrLoad = 8'(DRAIN_CYC - 1);

  pipe_state_e r_state, w_state_d, r_ret, w_ret_d, w_eff;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        w_ld_use, w_freeze, w_stall_inc, w_init;

  assign w_ld_use = exMemRd_IN && (exRd_IN != REG_ZERO) &&
                    ((idUsesRs_IN && (idRs_IN == exRd_IN)) ||
                     (idUsesRt_IN && (idRt_IN == exRd_IN)));

  // Once waiting, only the ack releases the freeze, whatever memReq does.
  assign w_freeze = (r_state == StMemWait) ? !memAck_IN : (memReq_IN && !memAck_IN);

  always_comb begin
    pcWr_OUT       = 1'b1;
    pcSelBr_OUT    = 1'b0;
    ifidWr_OUT     = 1'b1;
    ifidFlush_OUT  = 1'b0;
    idexWr_OUT     = 1'b1;
    idexFlush_OUT  = 1'b0;
    exmemWr_OUT    = 1'b1;
    memwbFlush_OUT = 1'b0;
    halted_OUT     = 1'b0;
    w_state_d      = r_state;
    w_ret_d        = r_ret;
    w_cnt_d        = r_cnt;
    w_eff          = (r_state == StMemWait) ? r_ret : r_state;

    if (r_state == StInit) begin
      pcWr_OUT       = 1'b0;
      ifidWr_OUT     = 1'b0;
      idexWr_OUT     = 1'b0;
      exmemWr_OUT    = 1'b0;
      ifidFlush_OUT  = 1'b1;
      idexFlush_OUT  = 1'b1;
      memwbFlush_OUT = 1'b1;
      w_state_d      = StRun;
    end else if (r_state == StHalted) begin
      pcWr_OUT    = 1'b0;
      ifidWr_OUT  = 1'b0;
      idexWr_OUT  = 1'b0;
      exmemWr_OUT = 1'b0;
      halted_OUT  = 1'b1;
      if (resume_IN) w_state_d = StRun;
    end else if (w_freeze) begin
      pcWr_OUT       = 1'b0;
      ifidWr_OUT     = 1'b0;
      idexWr_OUT     = 1'b0;
      exmemWr_OUT    = 1'b0;
      memwbFlush_OUT = 1'b1;
      w_state_d      = StMemWait;
      w_ret_d        = w_eff;
    end else begin
      // Ack cycle of a memory wait decodes as the state it interrupted.
      w_state_d = w_eff;
      case (w_eff)
        StRun: begin
          if (exBrTaken_IN) begin
            pcSelBr_OUT   = 1'b1;
            ifidFlush_OUT = 1'b1;
            idexFlush_OUT = 1'b1;
          end else if (w_ld_use) begin
            pcWr_OUT      = 1'b0;
            ifidWr_OUT    = 1'b0;
            idexFlush_OUT = 1'b1;
            w_cnt_d       = LdLoad;
            w_state_d     = (LDUSE_CYC > 1) ? StLdStall : StRun;
          end else if (haltReq_IN) begin
            pcWr_OUT      = 1'b0;
            ifidWr_OUT    = 1'b0;
            idexFlush_OUT = 1'b1;
            w_cnt_d       = DrLoad;
            w_state_d     = (DRAIN_CYC > 1) ? StDrain : StHalted;
          end
        end
        StLdStall: begin
          pcWr_OUT      = 1'b0;
          ifidWr_OUT    = 1'b0;
          idexFlush_OUT = 1'b1;
          w_cnt_d       = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) w_state_d = StRun;
        end
        StDrain: begin
          if (exBrTaken_IN) begin
            pcSelBr_OUT   = 1'b1;
            ifidFlush_OUT = 1'b1;
            idexFlush_OUT = 1'b1;
            w_cnt_d       = 8'd0;
            w_state_d     = StRun;
          end else begin
            pcWr_OUT      = 1'b0;
            ifidWr_OUT    = 1'b0;
            idexFlush_OUT = 1'b1;
            w_cnt_d       = r_cnt - 8'd1;
            if (r_cnt <= 8'd1) w_state_d = StHalted;
          end
        end
        default: w_state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StInit;
      r_ret   <= StRun;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_d;
      r_ret   <= w_ret_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign w_init      = (r_state == StInit);
  assign w_stall_inc = !pcWr_OUT && !w_init && (r_state != StHalted);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_IN  (w_stall_inc),
    .clr_IN  (w_init),
    .cnt_OUT (stallCnt_OUT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_IN  (pcSelBr_OUT),
    .clr_IN  (w_init),
    .cnt_OUT (flushCnt_OUT)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the pipeline sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned LDUSE = 1;
  localparam int unsigned DRAIN = 3;
  localparam int unsigned CW    = 16;
  localparam int          SAT   = 65535;

  // {pcWr, pcSelBr, ifidWr, ifidFlush, idexWr, idexFlush, exmemWr, memwbFlush, halted}
  typedef logic [8:0] out_t;
  localparam out_t O_IDLE = 9'b101010100;
  localparam out_t O_BUB  = 9'b000011100;
  localparam out_t O_BR   = 9'b111111100;
  localparam out_t O_FRZ  = 9'b000000010;
  localparam out_t O_INIT = 9'b000101010;
  localparam out_t O_HALT = 9'b000000001;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic [2:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       ack;
    logic       halt;
    logic       res;
  } in_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] idRs, idRt, exRd;
  logic idUsesRs, idUsesRt, exMemRd, exBrTaken, memReq, memAck, haltReq, resume;
  logic pcWr, pcSelBr, ifidWr, ifidFlush, idexWr, idexFlush, exmemWr, memwbFlush, halted;
  logic [CW-1:0] stallCnt, flushCnt;

  int errors = 0;
  int checks = 0;

  // Model state: pipeline phase flags plus remaining bubble/drain cycles.
  bit m_init = 1'b1, m_halted = 1'b0, m_wait = 1'b0;
  int m_bub = 0, m_drn = 0, m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LDUSE_CYC(LDUSE), .DRAIN_CYC(DRAIN), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .idRs_IN        (idRs),
    .idRt_IN        (idRt),
    .idUsesRs_IN    (idUsesRs),
    .idUsesRt_IN    (idUsesRt),
    .exRd_IN        (exRd),
    .exMemRd_IN     (exMemRd),
    .exBrTaken_IN   (exBrTaken),
    .memReq_IN      (memReq),
    .memAck_IN      (memAck),
    .haltReq_IN     (haltReq),
    .resume_IN      (resume),
    .pcWr_OUT       (pcWr),
    .pcSelBr_OUT    (pcSelBr),
    .ifidWr_OUT     (ifidWr),
    .ifidFlush_OUT  (ifidFlush),
    .idexWr_OUT     (idexWr),
    .idexFlush_OUT  (idexFlush),
    .exmemWr_OUT    (exmemWr),
    .memwbFlush_OUT (memwbFlush),
    .halted_OUT     (halted),
    .stallCnt_OUT   (stallCnt),
    .flushCnt_OUT   (flushCnt)
  );

  function automatic in_t mk(input int rs, input int rt, input bit urs, input bit urt,
                             input int rd, input bit ld, input bit br, input bit req,
                             input bit ack, input bit halt, input bit res);
    in_t v;
    v.rs = 3'(rs); v.rt = 3'(rt); v.urs = urs; v.urt = urt; v.rd = 3'(rd);
    v.ld = ld; v.br = br; v.req = req; v.ack = ack; v.halt = halt; v.res = res;
    return v;
  endfunction

  function automatic out_t dut_out();
    return {pcWr, pcSelBr, ifidWr, ifidFlush, idexWr, idexFlush, exmemWr, memwbFlush, halted};
  endfunction

  function automatic bit load_use(input in_t v);
    return v.ld && (v.rd != 3'd0) && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(input in_t v);
    idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt; exRd = v.rd;
    exMemRd = v.ld; exBrTaken = v.br; memReq = v.req; memAck = v.ack;
    haltReq = v.halt; resume = v.res;
  endtask

  // One clock: drive, check against model (and optional constant), advance model at the edge.
  task automatic step(input in_t v, input bit use_k, input out_t k, input string nm);
    out_t e;
    bit   fr;
    fr = 1'b0;
    drive(v);
    @(negedge clk);
    if (m_init) e = O_INIT;
    else if (m_halted) e = O_HALT;
    else if (m_wait ? !v.ack : (v.req && !v.ack)) begin e = O_FRZ; fr = 1'b1; end
    else if (m_drn > 0) e = v.br ? O_BR : O_BUB;
    else if (m_bub > 0) e = O_BUB;
    else if (v.br) e = O_BR;
    else if (load_use(v) || v.halt) e = O_BUB;
    else e = O_IDLE;
    chk({nm, "_model"}, 32'(dut_out()), 32'(e));
    if (use_k) chk(nm, 32'(dut_out()), 32'(k));
    chk({nm, "_stallcnt"}, 32'(stallCnt), 32'(m_stall));
    chk({nm, "_flushcnt"}, 32'(flushCnt), 32'(m_flush));
    @(posedge clk);
    if (!m_init && !m_halted && !e[8] && m_stall < SAT) m_stall++;
    if (e[7] && m_flush < SAT) m_flush++;
    if (m_init) m_init = 1'b0;
    else if (m_halted) begin
      if (v.res) m_halted = 1'b0;
    end else if (fr) m_wait = 1'b1;
    else begin
      m_wait = 1'b0;
      if (m_drn > 0) begin
        if (v.br) m_drn = 0;
        else begin
          m_drn--;
          if (m_drn == 0) m_halted = 1'b1;
        end
      end else if (m_bub > 0) m_bub--;
      else if (v.br) begin end
      else if (load_use(v)) m_bub = LDUSE - 1;
      else if (v.halt) begin
        m_drn = DRAIN - 1;
        if (m_drn == 0) m_halted = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("reset_decode", 32'(dut_out()), 32'(O_INIT));
    chk("reset_stallcnt", 32'(stallCnt), 32'd0);
    chk("reset_flushcnt", 32'(flushCnt), 32'd0);
    m_init = 1'b1; m_halted = 1'b0; m_wait = 1'b0;
    m_bub = 0; m_drn = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  in_t  idle, hz, tv;
  vec_t tbl[11];

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hz   = mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0);
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_IDLE};
    tbl[1]  = '{mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0), O_BUB};
    tbl[2]  = '{mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), O_IDLE};
    tbl[3]  = '{mk(0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0), O_IDLE};
    tbl[4]  = '{mk(1, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0), O_BUB};
    tbl[5]  = '{mk(3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0), O_IDLE};
    tbl[6]  = '{mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0), O_BR};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), O_IDLE};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), O_FRZ};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), O_BR};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_IDLE};
    drive(idle);

    do_reset();
    step(idle, 1'b1, O_INIT, "init_cycle");
    step(idle, 1'b1, O_IDLE, "run_after_init");

    for (int n = 0; n < 11; n++) step(tbl[n].i, 1'b1, tbl[n].o, $sformatf("vec%0d", n));
    chk("tbl_stallcnt", 32'(stallCnt), 32'd3);
    chk("tbl_flushcnt", 32'(flushCnt), 32'd2);

    // Memory wait with a pending taken branch: 4 frozen cycles, branch lands on ack.
    do_reset();
    step(idle, 1'b1, O_INIT, "mw_init");
    for (int n = 0; n < 4; n++)
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b1, O_FRZ, "mw_frozen");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 1'b1, O_BR, "mw_ack_branch");
    step(idle, 1'b1, O_IDLE, "mw_after");
    chk("mw_stallcnt", 32'(stallCnt), 32'd4);
    chk("mw_flushcnt", 32'(flushCnt), 32'd1);

    // Halt drains for 3 cycles, sits halted, then resumes.
    do_reset();
    step(idle, 1'b1, O_INIT, "h_init");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, O_BUB, "h_req");
    step(idle, 1'b1, O_BUB, "h_drain1");
    step(idle, 1'b1, O_BUB, "h_drain2");
    step(idle, 1'b1, O_HALT, "h_halted");
    step(hz, 1'b1, O_HALT, "h_halted_hz");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, O_HALT, "h_resume");
    step(idle, 1'b1, O_IDLE, "h_running");
    chk("h_stallcnt", 32'(stallCnt), 32'd3);

    // Taken branch in the second drain cycle cancels the halt.
    do_reset();
    step(idle, 1'b1, O_INIT, "ab_init");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, O_BUB, "ab_req");
    step(idle, 1'b1, O_BUB, "ab_drain1");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1, O_BR, "ab_branch");
    step(idle, 1'b1, O_IDLE, "ab_run");
    step(idle, 1'b1, O_IDLE, "ab_run2");
    chk("ab_flushcnt", 32'(flushCnt), 32'd1);
    chk("ab_stallcnt", 32'(stallCnt), 32'd2);

    // Reset in the middle of a drain returns straight to INIT.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, O_BUB, "rd_req");
    step(idle, 1'b1, O_BUB, "rd_drain1");
    do_reset();
    step(idle, 1'b1, O_INIT, "rd_init");
    step(idle, 1'b1, O_IDLE, "rd_run");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tv.rd   = 3'($urandom_range(0, 7));
      tv.rs   = ($urandom_range(0, 1) == 0) ? tv.rd : 3'($urandom_range(0, 7));
      tv.rt   = ($urandom_range(0, 1) == 0) ? tv.rd : 3'($urandom_range(0, 7));
      tv.urs  = 1'($urandom_range(0, 1));
      tv.urt  = 1'($urandom_range(0, 1));
      tv.ld   = 1'($urandom_range(0, 1));
      tv.br   = ($urandom_range(0, 7) == 0);
      tv.req  = ($urandom_range(0, 5) == 0);
      tv.ack  = 1'($urandom_range(0, 1));
      tv.halt = ($urandom_range(0, 15) == 0);
      tv.res  = ($urandom_range(0, 3) == 0);
      step(tv, 1'b0, O_IDLE, "rand");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
